// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Clocked, self-checking stimulus sequencer for a 3-input / 1-output
// combinational block. On an accepted start it walks abc through 0..7.
// Each code is held for SETTLE_CYCLES cycles and then sampled for one cycle.
// The sampled bits build table_q, and every sample that differs from EXPECTED
// increments err_count.
//
// Parameters:
//   SETTLE_CYCLES - cycles abc is held before y is sampled (legal 1..15)
//   EXPECTED      - golden truth table, bit i = expected y for abc == i
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset
//   start     in   begin a sweep (only looked at in IDLE)
//   y         in   output of the combinational block under test
//   abc       out  [2:0] drives the block inputs {a,b,c}, a is the MSB
//   busy      out  high while a vector is settling or being sampled
//   done      out  one-cycle pulse when the sweep finishes
//   table_q   out  [7:0] captured truth table, bit i = y sampled at abc == i
//   err_count out  [3:0] number of samples differing from EXPECTED (0..8)
//   mismatch  out  err_count != 0
//
// Build option:
//   SWEEP_STOP_ON_ERR_EN - when defined, the first mismatching sample ends
//                          the sweep at once (err_count = 1, done pulses).
//                          Bits of table_q above that index stay 0.
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECTED      = 8'h68
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic [2:0] abc,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_q,
    output logic [3:0] err_count,
    output logic       mismatch
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Terminal value of the settle counter; SETTLE lasts SETTLE_CYCLES cycles.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] table_d;
    logic [3:0] err_d;
    logic       sample_bad;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: registers are written with non-blocking assignments only, so that
    // every flop samples the values from before the edge, whatever the
    // statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            cnt_q     <= 4'd0;
            table_q   <= 8'h00;
            err_count <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            table_q   <= table_d;
            err_count <= err_d;
        end
    end

    // The sample disagrees with the golden table entry for the current code.
    assign sample_bad = (y != EXPECTED[idx_q]);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first. A path
    // that skips an assignment would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        err_d   = err_count;
        abc     = 3'd0;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = 3'd0;
                    cnt_d   = 4'd0;
                    table_d = 8'h00;
                    err_d   = 4'd0;
                    state_d = S_SETTLE;
                end
            end

            S_SETTLE: begin
                abc  = idx_q;
                busy = 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_SAMPLE: begin
                abc            = idx_q;
                busy           = 1'b1;
                table_d[idx_q] = y;
                if (sample_bad) begin
                    err_d = err_count + 4'd1;
                end
`ifdef SWEEP_STOP_ON_ERR_EN
                // err_count is still zero here on the first bad sample,
                // so the increment above leaves exactly 1.
                if (sample_bad || idx_q == 3'd7) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_SETTLE;
                end
`else
                // Leave for DONE before idx could wrap past 7.
                if (idx_q == 3'd7) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_SETTLE;
                end
`endif
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign mismatch = (err_count != 4'd0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Bench for truth_table_sweeper. The block under test is modelled as an 8-bit
// truth table fn (y = fn[abc]). A reference model derives the expected table,
// the mismatch count and the done cycle directly from the sweep rules. Inputs
// change after the rising edge, and outputs are checked on the falling edge.
// Cycle c is the interval between rising edge c-1 and rising edge c, where
// edge 0 is the one that accepts start.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    localparam int unsigned S   = 2;
    localparam logic [7:0]  EXP = 8'h68;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       y;
    logic [2:0] abc;
    logic       busy;
    logic       done;
    logic [7:0] table_q;
    logic [3:0] err_count;
    logic       mismatch;

    logic [7:0] fn;        // truth table of the block under test
    logic [7:0] golden_fn; // exactly-two-of-three detector

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign y = fn[abc];

    truth_table_sweeper #(
        .SETTLE_CYCLES(S),
        .EXPECTED     (EXP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .y        (y),
        .abc      (abc),
        .busy     (busy),
        .done     (done),
        .table_q  (table_q),
        .err_count(err_count),
        .mismatch (mismatch)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: walks the eight codes in order and applies the sweep
    // rules to the block's truth table.
    function automatic void model(input logic [7:0] f, output logic [7:0] t,
                                  output int e, output int dc);
        t  = 8'h00;
        e  = 0;
        dc = 8 * (S + 1) + 1;
        for (int i = 0; i < 8; i++) begin
            t[i] = f[i];
            if (f[i] != EXP[i]) begin
                e++;
`ifdef SWEEP_STOP_ON_ERR_EN
                dc = (i + 1) * (S + 1) + 1;
                break;
`endif
            end
        end
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_abc"},  32'(abc),       32'd0);
        check({tag, "_busy"}, 32'(busy),      32'd0);
        check({tag, "_done"}, 32'(done),      32'd0);
        check({tag, "_tab"},  32'(table_q),   32'd0);
        check({tag, "_err"},  32'(err_count), 32'd0);
        check({tag, "_mis"},  32'(mismatch),  32'd0);
    endtask

    // One full sweep with cycle-by-cycle checks of abc, busy and done.
    // If repulse is set, start is raised again during cycles 5 and 24.
    task automatic run_sweep(input logic [7:0] f, input bit repulse, input string tag);
        logic [7:0] et;
        int         ee;
        int         edc;
        model(f, et, ee, edc);
        fn = f;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);        // edge 0
        #1 start = 1'b0;
        for (int c = 1; c <= edc; c++) begin
            @(negedge clk);
            if (repulse) start = (c == 5 || c == 24);
            check($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(c == edc));
            check($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(c != edc));
            check($sformatf("%s_abc_c%0d", tag, c), 32'(abc),
                  (c == edc) ? 32'd0 : 32'((c - 1) / (S + 1)));
        end
        start = 1'b0;
        check({tag, "_table"},    32'(table_q),   32'(et));
        check({tag, "_err"},      32'(err_count), 32'(ee));
        check({tag, "_mismatch"}, 32'(mismatch),  32'(ee != 0));
        // The results are held in IDLE after done.
        repeat (3) @(negedge clk);
        check({tag, "_done_after"}, 32'(done),      32'd0);
        check({tag, "_busy_after"}, 32'(busy),      32'd0);
        check({tag, "_table_hold"}, 32'(table_q),   32'(et));
        check({tag, "_err_hold"},   32'(err_count), 32'(ee));
    endtask

    initial begin
        logic [7:0] rnd;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] code;
            code         = 3'(i);
            golden_fn[i] = ($countones(code) == 2);
        end
        fn    = golden_fn;
        rst   = 1'b1;
        start = 1'b1;   // reset must override start
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst   = 1'b0;
        start = 1'b0;

        // Golden detector, plus direct checks of the known answer.
        run_sweep(golden_fn, 1'b0, "golden");
        check("golden_table_const", 32'(table_q),   32'h68);
        check("golden_err_const",   32'(err_count), 32'd0);

        // Inverted detector, then a block stuck at 0.
        run_sweep(~golden_fn, 1'b0, "inverted");
        run_sweep(8'h00, 1'b0, "stuck0");

        // Start pulses during a sweep are ignored.
        run_sweep(golden_fn, 1'b1, "repulse");

        // Reset during vector idx=4 (cycles 13..15): results are discarded and
        // no done pulse follows.
        fn = golden_fn;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(negedge clk);     // now in cycle 14
        check("midrst_busy_before", 32'(busy), 32'd1);
        check("midrst_abc_before",  32'(abc),  32'd4);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check($sformatf("midrst_nodone_%0d", c), 32'(done), 32'd0);
        end
        run_sweep(golden_fn, 1'b0, "after_rst");

        // Blocks with random truth tables.
        for (int r = 0; r < 4; r++) begin
            rnd = 8'($urandom);
            run_sweep(rnd, 1'b0, $sformatf("rand%0d_%02h", r, rnd));
        end

        // start held high re-triggers from the IDLE cycle after DONE:
        // DONE in cycle 25, IDLE in cycle 26, next sweep settling in cycle 27.
        fn = golden_fn;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            if (c == 25) check("hold_done_25", 32'(done), 32'd1);
            if (c == 26) check("hold_idle_26", 32'(busy), 32'd0);
            if (c == 27) begin
                check("hold_busy_27", 32'(busy),    32'd1);
                check("hold_abc_27",  32'(abc),     32'd0);
                check("hold_tab_27",  32'(table_q), 32'd0);
            end
        end
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("final_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
